// File: rtl/crc5_check.sv
// crc5_check: serial USB CRC5 checker (x^5+x^2+1, seed 5'b11111).
// Incoming frame bits are delayed through a 5-bit window so that the trailing
// CRC field is never forwarded. The bits leaving the window are data bits: they
// are forwarded on outb and folded into the running CRC. When recving drops,
// the window holds the received CRC, and it is compared with the running CRC.
// Optional feature macro: CRC5_INV_EN. When it is defined, the received CRC is
// compared with the complemented CRC, as it appears on the USB wire.
module crc5_check (
    input  logic clk,
    input  logic rst_L,
    input  logic inb,
    input  logic recving,
    input  logic pause_in,
    output logic outb,
    output logic out_valid,
    output logic sending,
    output logic done,
    output logic crc_ok,
    output logic crc_err,
    output logic len_err
);

    localparam logic [4:0] CRC_SEED = 5'b11111;
    localparam logic [4:0] CRC_POLY = 5'b00101;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILL,
        ST_PASS,
        ST_CHECK
    } state_t;

    state_t     state_q;
    logic [2:0] cnt_q;
    logic [4:0] shift_q;     // delay window, shift_q[0] is the newest bit
    logic [4:0] crc_q;
    logic       outb_q;
    logic       out_valid_q;
    logic       sending_q;
    logic       done_q;
    logic       crc_ok_q;
    logic       crc_err_q;
    logic       len_err_q;

    logic [4:0] shift_d;
    logic [4:0] crc_d;
    logic [4:0] crc_expected;
    logic       short_frame;
    logic       match;

    // Next window and next CRC for an accepted bit, plus the end-of-frame verdict
    always_comb begin
        shift_d = {shift_q[3:0], inb};
        crc_d   = {crc_q[3:0], 1'b0} ^ ((crc_q[4] ^ shift_q[4]) ? CRC_POLY : 5'b00000);
`ifdef CRC5_INV_EN
        crc_expected = ~crc_q;
`else
        crc_expected = crc_q;
`endif
        short_frame = (cnt_q < 3'd5);
        match       = !short_frame && (shift_q == crc_expected);
    end

    // Frame FSM; every output is registered and is computed one cycle ahead
    always_ff @(posedge clk) begin
        if (!rst_L) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            shift_q     <= 5'b00000;
            crc_q       <= CRC_SEED;
            outb_q      <= 1'b0;
            out_valid_q <= 1'b0;
            sending_q   <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
        end else begin
            // Strobes and verdict flags are single-cycle unless set below
            outb_q      <= 1'b0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b0;
            crc_ok_q    <= 1'b0;
            crc_err_q   <= 1'b0;
            len_err_q   <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    crc_q     <= CRC_SEED;
                    cnt_q     <= 3'd0;
                    shift_q   <= 5'b00000;
                    sending_q <= recving;
                    if (recving) begin
                        state_q <= ST_FILL;
                        if (!pause_in) begin
                            shift_q <= {4'b0000, inb};
                            cnt_q   <= 3'd1;
                        end
                    end
                end
                ST_FILL, ST_PASS: begin
                    if (!recving) begin
                        // The bit present in this cycle is ignored.
                        state_q   <= ST_CHECK;
                        sending_q <= 1'b0;
                        done_q    <= 1'b1;
                        crc_ok_q  <= match;
                        crc_err_q <= !match;
                        len_err_q <= short_frame;
                    end else if (!pause_in) begin
                        shift_q <= shift_d;
                        if (state_q == ST_FILL) begin
                            cnt_q <= cnt_q + 3'd1;
                            if (cnt_q == 3'd4) begin
                                state_q <= ST_PASS;
                            end
                        end else begin
                            // The bit leaving the window is a data bit.
                            outb_q      <= shift_q[4];
                            out_valid_q <= 1'b1;
                            crc_q       <= crc_d;
                        end
                    end
                end
                ST_CHECK: begin
                    crc_q     <= CRC_SEED;
                    cnt_q     <= 3'd0;
                    shift_q   <= 5'b00000;
                    sending_q <= recving;
                    if (recving) begin
                        // A back-to-back frame starts in this cycle.
                        state_q <= ST_FILL;
                        if (!pause_in) begin
                            shift_q <= {4'b0000, inb};
                            cnt_q   <= 3'd1;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q   <= ST_IDLE;
                    sending_q <= 1'b0;
                end
            endcase
        end
    end

    assign outb      = outb_q;
    assign out_valid = out_valid_q;
    assign sending   = sending_q;
    assign done      = done_q;
    assign crc_ok    = crc_ok_q;
    assign crc_err   = crc_err_q;
    assign len_err   = len_err_q;

endmodule

// File: tb/tb_crc5_check.sv
// tb_crc5_check: directed, table-driven bench for crc5_check.
// Each row holds one cycle of inputs and the outputs expected after that edge,
// packed as {outb, out_valid, sending, done, crc_ok, crc_err, len_err}.
module tb_crc5_check;

    logic clk = 1'b0;
    logic rst_L;
    logic inb;
    logic recving;
    logic pause_in;
    logic outb;
    logic out_valid;
    logic sending;
    logic done;
    logic crc_ok;
    logic crc_err;
    logic len_err;

    always #5 clk = ~clk;

    crc5_check dut (
        .clk       (clk),
        .rst_L     (rst_L),
        .inb       (inb),
        .recving   (recving),
        .pause_in  (pause_in),
        .outb      (outb),
        .out_valid (out_valid),
        .sending   (sending),
        .done      (done),
        .crc_ok    (crc_ok),
        .crc_err   (crc_err),
        .len_err   (len_err)
    );

    typedef struct {
        logic       rec;
        logic       pau;
        logic       bin;
        logic [6:0] exp;
    } vec_t;

    localparam logic [6:0] IDL  = 7'b0000000;
    localparam logic [6:0] SND  = 7'b0010000;
    localparam logic [6:0] O1   = 7'b1110000;
    localparam logic [6:0] O0   = 7'b0110000;
    localparam logic [6:0] DOK  = 7'b0001100;
    localparam logic [6:0] DER  = 7'b0001010;
    localparam logic [6:0] DLEN = 7'b0001011;

    // Frame of REQ-031: data 1000, CRC 01011
    localparam logic [8:0] FRAME_A = 9'b100001011;
    // Same frame with the last bit flipped
    localparam logic [8:0] FRAME_B = 9'b100001010;
    // Data 1000 followed by the complemented CRC 10100
    localparam logic [8:0] FRAME_I = 9'b100010100;

`ifdef CRC5_INV_EN
    localparam logic [6:0] DN_A     = DER;
    localparam logic [6:0] DN_11111 = DER;
`else
    localparam logic [6:0] DN_A     = DOK;
    localparam logic [6:0] DN_11111 = DOK;
`endif

    vec_t vecs[256];
    int   nvec   = 0;
    int   checks = 0;
    int   errors = 0;
    int   frame_a_end;

    task automatic add(input logic r, input logic p, input logic b, input logic [6:0] e);
        vecs[nvec].rec = r;
        vecs[nvec].pau = p;
        vecs[nvec].bin = b;
        vecs[nvec].exp = e;
        nvec++;
    endtask

    // Bits from..8 of a 9-bit frame (f[8] sent first) with no stalls. The first
    // five bits only fill the window; each later bit pushes out bit i-5.
    task automatic add_bits(input logic [8:0] f, input int from);
        for (int i = from; i < 9; i++) begin
            if (i < 5) add(1'b1, 1'b0, f[8-i], SND);
            else       add(1'b1, 1'b0, f[8-i], f[8-(i-5)] ? O1 : O0);
        end
    endtask

    task automatic check(input string name, input logic [6:0] got, input logic [6:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got=%b want=%b (outb,valid,sending,done,ok,err,len)", name, got, want);
        end else begin
            $display("ok   %s out=%b", name, got);
        end
    endtask

    function automatic logic [6:0] outs();
        return {outb, out_valid, sending, done, crc_ok, crc_err, len_err};
    endfunction

    task automatic drive(input logic r, input logic p, input logic b);
        @(negedge clk);
        recving  = r;
        pause_in = p;
        inb      = b;
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int i);
        drive(vecs[i].rec, vecs[i].pau, vecs[i].bin);
        check($sformatf("vec%0d r%0b p%0b b%0b", i, vecs[i].rec, vecs[i].pau, vecs[i].bin),
              outs(), vecs[i].exp);
    endtask

    initial begin
        // Good frame, then an idle cycle
        add_bits(FRAME_A, 0);
        add(1'b0, 1'b0, 1'b0, DN_A);
        add(1'b0, 1'b0, 1'b0, IDL);
        frame_a_end = nvec;
        // Last bit flipped
        add_bits(FRAME_B, 0);
        add(1'b0, 1'b0, 1'b0, DER);
        add(1'b0, 1'b0, 1'b0, IDL);
        // Good frame stalled 3 cycles after bit 2 and after bit 7; stalled inb is junk
        add(1'b1, 1'b0, 1'b1, SND);
        add(1'b1, 1'b0, 1'b0, SND);
        add(1'b1, 1'b1, 1'b1, SND);
        add(1'b1, 1'b1, 1'b1, SND);
        add(1'b1, 1'b1, 1'b1, SND);
        add(1'b1, 1'b0, 1'b0, SND);
        add(1'b1, 1'b0, 1'b0, SND);
        add(1'b1, 1'b0, 1'b0, SND);
        add(1'b1, 1'b0, 1'b1, O1);
        add(1'b1, 1'b0, 1'b0, O0);
        add(1'b1, 1'b1, 1'b1, SND);
        add(1'b1, 1'b1, 1'b1, SND);
        add(1'b1, 1'b1, 1'b1, SND);
        add(1'b1, 1'b0, 1'b1, O0);
        add(1'b1, 1'b0, 1'b1, O0);
        add(1'b0, 1'b0, 1'b0, DN_A);
        add(1'b0, 1'b0, 1'b0, IDL);
        // Five-bit frame: no data, checked against the seed
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, 1'b1, SND);
        add(1'b0, 1'b0, 1'b0, DN_11111);
        add(1'b0, 1'b0, 1'b0, IDL);
        // Short frame 1,0,1
        add(1'b1, 1'b0, 1'b1, SND);
        add(1'b1, 1'b0, 1'b0, SND);
        add(1'b1, 1'b0, 1'b1, SND);
        add(1'b0, 1'b0, 1'b0, DLEN);
        add(1'b0, 1'b0, 1'b0, IDL);
        // Back-to-back: the second frame's first bit arrives in the CHECK cycle
        add_bits(FRAME_A, 0);
        add(1'b0, 1'b0, 1'b0, DN_A);
        add(1'b1, 1'b0, 1'b1, SND);
        add_bits(FRAME_A, 1);
        add(1'b0, 1'b0, 1'b0, DN_A);
        add(1'b0, 1'b0, 1'b0, IDL);
        // Frame starts with a stall in IDLE; that bit must not be taken
        add(1'b1, 1'b1, 1'b0, SND);
        add_bits(FRAME_A, 0);
        add(1'b0, 1'b0, 1'b0, DN_A);
        add(1'b0, 1'b0, 1'b0, IDL);
`ifdef CRC5_INV_EN
        add_bits(FRAME_I, 0);
        add(1'b0, 1'b0, 1'b0, DOK);
        add(1'b0, 1'b0, 1'b0, IDL);
`endif

        // Reset state
        rst_L    = 1'b0;
        recving  = 1'b0;
        pause_in = 1'b0;
        inb      = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset", outs(), IDL);
        @(negedge clk);
        rst_L = 1'b1;

        for (int i = 0; i < nvec; i++) run_vec(i);

        // Reset in the middle of PASS: frame dropped with no done pulse
        for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, FRAME_A[8-i]);
        check("pre_rst_pass", outs(), O0);
        @(negedge clk);
        rst_L = 1'b0;
        inb   = 1'b1;
        @(posedge clk);
        #1;
        check("rst_mid_pass", outs(), IDL);
        @(negedge clk);
        rst_L   = 1'b1;
        recving = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst_idle%0d", i), outs(), IDL);
        end
        // Recovery from IDLE: good frame again
        for (int i = 0; i < frame_a_end; i++) run_vec(i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
